// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer/flag controller for the dual-clock FIFO: synchronizes the Gray write pointer, tracks the read pointer.
// Optional almost-empty flag is built when FIFO_ALMOST_EMPTY_EN is defined.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  parameter int ALMOST_EMPTY_THRESH = 2
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wptr_gray_async,
  input  logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wbin_sync;
  logic [PW-1:0] rptr_bin_q, rptr_bin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          underflow_q, underflow_d;
  logic          rd_fire;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Plain flop chain: nothing may sit between stages of the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wptr_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wptr_sync = sync_q[SYNC_STAGES-1];
  assign wbin_sync = gray2bin(wptr_sync);

  always_comb begin
    rd_fire     = rd_en & ~empty_q;
    rptr_bin_d  = rptr_bin_q + {{ADDR_WIDTH{1'b0}}, rd_fire};
    rptr_gray_d = rptr_bin_d ^ (rptr_bin_d >> 1);
    // Full-width compare: the MSB separates a full lap from an empty FIFO.
    empty_d     = (rptr_gray_d == wptr_sync);
    level_d     = wbin_sync - rptr_bin_d;
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= rptr_gray_d;
      level_q     <= level_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  localparam logic [PW-1:0] AE_THRESH = PW'(ALMOST_EMPTY_THRESH);
  logic almost_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_empty_q <= 1'b1;
    end else begin
      almost_empty_q <= (level_d <= AE_THRESH);
    end
  end

  assign almost_empty = almost_empty_q;
`endif

  assign rd_addr   = rptr_bin_q[ADDR_WIDTH-1:0];
  assign rptr_gray = rptr_gray_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Randomized and directed bench for fifo_read_ctrl against an occupancy-counting reference model.
module tb_fifo_read_ctrl;
  localparam int AW = 4;
  localparam int SS = 2;
  localparam int PW = AW + 1;
  localparam int MODV = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] wptr_gray_async;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rptr_gray;
  logic          empty;
  logic [PW-1:0] level;
  logic          underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic          almost_empty;
`endif

  fifo_read_ctrl #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .ALMOST_EMPTY_THRESH(2)
`endif
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wptr_gray_async(wptr_gray_async),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rptr_gray      (rptr_gray),
    .empty          (empty),
    .level          (level),
    .underflow      (underflow)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .almost_empty   (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: counts of words written and read, plus the write counts seen at past edges.
  int unsigned wcnt;
  int unsigned rcount;
  int unsigned wq[$];
  int unsigned exp_level;
  bit          exp_empty;
  bit          exp_uf;

  function automatic logic [PW-1:0] to_gray(input int unsigned b);
    logic [PW-1:0] x;
    x = PW'(b % MODV);
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("level", 32'(level), exp_level);
    check("empty", 32'(empty), 32'(exp_empty));
    check("rptr_gray", 32'(rptr_gray), 32'(to_gray(rcount)));
    check("rd_addr", 32'(rd_addr), rcount % 16);
    check("underflow", 32'(underflow), 32'(exp_uf));
`ifdef FIFO_ALMOST_EMPTY_EN
    check("almost_empty", 32'(almost_empty), 32'(exp_level <= 2));
`endif
  endtask

  task automatic step();
    int unsigned vis;
    bit          pop;
    wptr_gray_async = to_gray(wcnt);
    @(posedge clk);
    if (reset) begin
      wq.delete();
      rcount    = 0;
      exp_level = 0;
      exp_empty = 1'b1;
      exp_uf    = 1'b0;
    end else begin
      pop = rd_en && !exp_empty;
      if (rd_en && exp_empty) exp_uf = 1'b1;
      rcount = (rcount + (pop ? 1 : 0)) % MODV;
      wq.push_back(wcnt % MODV);
      if (wq.size() > SS + 1) void'(wq.pop_front());
      // Write count sampled SS edges ago is what the read side can see now.
      vis = (wq.size() > SS) ? wq[wq.size() - 1 - SS] : 0;
      exp_level = (vis + MODV - rcount) % MODV;
      exp_empty = (exp_level == 0);
    end
    #1;
    check_all();
  endtask

  function automatic int unsigned occ();
    return (wcnt + MODV - rcount) % MODV;
  endfunction

  initial begin
    logic [4:0] ae_seq;
    wcnt   = 0;
    rcount = 0;
    exp_level = 0;
    exp_empty = 1'b1;
    exp_uf = 1'b0;
    reset = 1'b1;
    rd_en = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      wcnt  = $urandom_range(0, 31);
      step();
    end
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_gray", 32'(rptr_gray), 32'd0);
    check("rst_level", 32'(level), 32'd0);

    // Single write visibility
    reset = 1'b0;
    rd_en = 1'b0;
    wcnt  = 0;
    step();
    wcnt = 1;
    step();
    check("vis_edge1_empty", 32'(empty), 32'd1);
    step();
    check("vis_edge2_empty", 32'(empty), 32'd1);
    step();
    check("vis_edge3_empty", 32'(empty), 32'd0);
    check("vis_edge3_level", 32'(level), 32'd1);

    // Drain 16 words
    reset = 1'b1;
    step();
    reset = 1'b0;
    wcnt  = 16;
    for (int i = 0; i < 4; i++) step();
    check("drain_full_level", 32'(level), 32'd16);
    rd_en = 1'b1;
    for (int i = 0; i < 18; i++) step();
    rd_en = 1'b0;
    check("drain_gray", 32'(rptr_gray), 32'h18);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_uf", 32'(underflow), 32'd1);

    // Randomized traffic
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rd_en = ($urandom_range(0, 99) < 45);
      if (occ() < 16 && $urandom_range(0, 99) < 50) wcnt = (wcnt + 1) % MODV;
      step();
    end

    // Wrap: pop 31 entries then cross into the next lap
    reset = 1'b1;
    rd_en = 1'b0;
    wcnt  = 0;
    step();
    reset = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (rcount == 31) break;
      if (wcnt != 31 && occ() < 16) wcnt = wcnt + 1;
      step();
    end
    rd_en = 1'b0;
    wcnt  = 0;
    for (int i = 0; i < 3; i++) step();
    check("wrap_pre_addr", 32'(rd_addr), 32'd15);
    check("wrap_pre_gray", 32'(rptr_gray), 32'h10);
    check("wrap_pre_level", 32'(level), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("wrap_gray", 32'(rptr_gray), 32'h00);
    check("wrap_addr", 32'(rd_addr), 32'd0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset while a pointer change is in the synchronizer
    reset = 1'b1;
    step();
    reset = 1'b0;
    wcnt  = 5;
    for (int i = 0; i < 4; i++) step();
    check("mid_level5", 32'(level), 32'd5);
    wcnt = 6;
    step();
    reset = 1'b1;
    wcnt  = 0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mid_stale_empty", 32'(empty), 32'd1);
      check("mid_stale_level", 32'(level), 32'd0);
    end

`ifdef FIFO_ALMOST_EMPTY_EN
    // Almost-empty threshold walk
    wcnt = 4;
    for (int i = 0; i < 4; i++) step();
    ae_seq[0] = almost_empty;
    rd_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      ae_seq[i] = almost_empty;
    end
    rd_en = 1'b0;
    check("ae_seq", 32'(ae_seq), 32'(5'b11100));
`else
    ae_seq = 5'b00000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
